conv_window_gen: RTL
====================

Name: conv_window_gen

Overview:
- Streaming sliding-window generator; acts as the producer side of the convolution datapath.
- Accepts one unsigned pixel per cycle in raster order.
- Buffers FILTER_SIZE-1 image rows internally.
- Emits a packed FILTER_SIZE x FILTER_SIZE window with a valid strobe for every stride-1 "valid" (unpadded) convolution position. This bus feeds the conv calculator's data_in/in_val inputs directly.

Parameters:
- FILTER_SIZE, 5, window edge length in pixels.
- DATA_BITS, 8, unsigned pixel width.
- IMG_WIDTH, 28, pixels per row; must be >= FILTER_SIZE.
- IMG_HEIGHT, 28, rows per frame; must be >= FILTER_SIZE.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- pix_in  in  DATA_BITS  unsigned pixel.
- pix_val  in  1  pix_in valid this cycle; gaps allowed.
- sof  in  1  start of frame; qualified by pix_val.
- data_out  out  FILTER_SIZE*FILTER_SIZE*DATA_BITS  packed window; element i=r*FILTER_SIZE+c at bits [i*DATA_BITS +: DATA_BITS].
- valid  out  1  data_out holds a complete window, 1-cycle pulse.
- frame_done  out  1  1-cycle pulse with the last window of a frame.

Behaviour:
- Reset (async, rst_n=0): col_cnt=0, row_cnt=0, valid=0, frame_done=0, data_out=0, window registers=0. Line-buffer storage is not cleared; its contents are don't-care because validity is gated by row_cnt.
- Accept: a pixel is consumed only when pix_val=1. With pix_val=0, all state holds, including data_out; valid and frame_done go 0.
- Counters:
  - col_cnt 0..IMG_WIDTH-1, row_cnt 0..IMG_HEIGHT-1, advanced per accepted pixel.
  - col wraps to 0 and increments row.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0.
- sof:
  - sof=1 with pix_val=1: this pixel is (0,0) regardless of current counters. A frame in progress is abandoned with no flag and no stale windows; the counter restart guarantees this.
  - sof=1 with pix_val=0: ignored.
  - sof is not required; counters free-run frame to frame.
- Line buffers: FILTER_SIZE-1 row-delay lines, each IMG_WIDTH deep, shifting only on accept. Tap k gives the pixel k rows above the current column.
- Window: FILTER_SIZE column shift registers loaded from {taps, pix_in} on accept. After accepting pixel (R,C), element (r,c) = pixel(R-(FILTER_SIZE-1)+r, C-(FILTER_SIZE-1)+c). Element 0 is the top-left (oldest) pixel; the last element is the pixel just accepted.
- valid: registered; asserted on the cycle after accepting (R,C) iff R>=FILTER_SIZE-1 and C>=FILTER_SIZE-1. Latency is 1 cycle from the completing pixel.
- Window count: (IMG_HEIGHT-FILTER_SIZE+1)*(IMG_WIDTH-FILTER_SIZE+1) windows per frame, i.e. 576 at defaults.
- Row boundary: no valid for C<FILTER_SIZE-1. Columns spanning a row wrap are never emitted.
- frame_done: asserted together with valid for pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- No backpressure. The consumer must accept every valid pulse.
- Arithmetic: pure data movement; no widening or sign change. Downstream zero-extends pixels.

Optional Feature:
- Macro CONV_WIN_STRIDE2_EN.
- Defined: valid (and frame_done) only when (R-(FILTER_SIZE-1)) and (C-(FILTER_SIZE-1)) are both even, giving stride 2. Defaults yield 12*12=144 windows. frame_done still fires on the final pixel even if that position is odd; in that case it pulses with valid=0.
- Undefined: stride 1 as above.

Decomposition:
- Package conv_pkg:
  - constants FILTER_SIZE, DATA_BITS, WIN_ELEMS=FILTER_SIZE*FILTER_SIZE, WIN_BITS=WIN_ELEMS*DATA_BITS;
  - counter widths $clog2(IMG_WIDTH), $clog2(IMG_HEIGHT);
  - typedef pixel_t = logic [DATA_BITS-1:0].
- One sub-module, conv_line_buffer: single row delay, depth IMG_WIDTH, enable-gated, DATA_BITS wide. It is instantiated FILTER_SIZE-1 times in a chain.

Test Plan (small config FILTER_SIZE=3, IMG_WIDTH=8, IMG_HEIGHT=6, pixel=R*8+C unless noted):
- Contiguous frame → first valid one cycle after pixel 18; data_out elements 0..8 = 0,1,2,8,9,10,16,17,18. Exactly 24 valid pulses; last window = 29,30,31,37,38,39,45,46,47 with frame_done=1.
- Random pix_val gaps (about 50% duty) → same 24 windows, same order and contents; data_out stable during gaps; valid never high in a gap-following idle cycle.
- sof with pix_val at pixel 30 mid-frame, then a new frame → no window mixing old rows. The first valid follows new pixel (2,2), contents 0,1,2,8,9,10,16,17,18.
- rst_n low mid-frame (after pixel 25), release, new frame → valid/frame_done/data_out are 0 during reset; afterwards the 24 correct windows appear.
- Defaults (5x5, 28x28), pixel=(R+C)&0xFF → 576 valid pulses; window at (R=4,C=4) element i = (i/5)+(i%5).
- CONV_WIN_STRIDE2_EN, small config → 6 windows, top-left corners (0,0),(0,2),(0,4),(2,0),(2,2),(2,4). frame_done pulses on pixel 47 with valid=0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution window datapath.
package conv_pkg;

  localparam int FILTER_SIZE = 5;
  localparam int DATA_BITS   = 8;
  localparam int IMG_WIDTH   = 28;
  localparam int IMG_HEIGHT  = 28;
  localparam int WIN_ELEMS   = FILTER_SIZE * FILTER_SIZE;
  localparam int WIN_BITS    = WIN_ELEMS * DATA_BITS;
  localparam int COL_W       = $clog2(IMG_WIDTH);
  localparam int ROW_W       = $clog2(IMG_HEIGHT);

  typedef logic [DATA_BITS-1:0] pixel_t;

  // Counter width that stays legal for a degenerate extent of one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image-row delay line addressed by the column counter; storage is never reset.
module conv_line_buffer #(
  parameter int DATA_BITS = conv_pkg::DATA_BITS,
  parameter int DEPTH     = conv_pkg::IMG_WIDTH,
  parameter int ADDR_W    = conv_pkg::COL_W
) (
  input  logic                 clk_i,
  input  logic                 en_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [DATA_BITS-1:0] din_i,
  output logic [DATA_BITS-1:0] dout_o
);
  import conv_pkg::*;

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  // Read-before-write at the same column yields the pixel one row above.
  assign dout_o = mem_q[addr_i];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      mem_q[addr_i] <= din_i;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming sliding-window generator: raster pixels in, packed FILTER_SIZE^2 window out.
// Define CONV_WIN_STRIDE2_EN to emit only even-offset (stride-2) window positions.
module conv_window_gen #(
  parameter int FILTER_SIZE = conv_pkg::FILTER_SIZE,
  parameter int DATA_BITS   = conv_pkg::DATA_BITS,
  parameter int IMG_WIDTH   = conv_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT  = conv_pkg::IMG_HEIGHT
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [DATA_BITS-1:0]                       pix_in,
  input  logic                                       pix_val,
  input  logic                                       sof,
  output logic [FILTER_SIZE*FILTER_SIZE*DATA_BITS-1:0] data_out,
  output logic                                       valid,
  output logic                                       frame_done
);
  import conv_pkg::*;

  localparam int CW   = cnt_w(IMG_WIDTH);
  localparam int RW   = cnt_w(IMG_HEIGHT);
  localparam int NTAP = FILTER_SIZE - 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(FILTER_SIZE - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(FILTER_SIZE - 1);
  localparam logic          FS_PAR    = 1'((FILTER_SIZE - 1) % 2);

  logic [CW-1:0]        col_q, col_d, col_cur;
  logic [RW-1:0]        row_q, row_d, row_cur;
  logic                 valid_q, valid_d;
  logic                 fdone_q, fdone_d;
  logic                 sof_acc, stride_ok, win_hit, last_pix;
  logic [DATA_BITS-1:0] tap   [FILTER_SIZE];
  logic [DATA_BITS-1:0] win_q [FILTER_SIZE][FILTER_SIZE];

  // An accepted sof forces this pixel to (0,0), discarding any partial frame.
  assign sof_acc = pix_val & sof;
  assign col_cur = sof_acc ? '0 : col_q;
  assign row_cur = sof_acc ? '0 : row_q;

`ifdef CONV_WIN_STRIDE2_EN
  assign stride_ok = (row_cur[0] == FS_PAR) && (col_cur[0] == FS_PAR);
`else
  assign stride_ok = 1'b1;
`endif

  assign win_hit  = (row_cur >= ROW_FIRST) && (col_cur >= COL_FIRST);
  assign last_pix = (row_cur == ROW_LAST) && (col_cur == COL_LAST);

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    fdone_d = 1'b0;
    if (pix_val) begin
      valid_d = win_hit & stride_ok;
      fdone_d = last_pix;
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + RW'(1);
      end else begin
        col_d = col_cur + CW'(1);
        row_d = row_cur;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      fdone_q <= fdone_d;
    end
  end

  // Tap k is the pixel k rows above the current column.
  assign tap[0] = pix_in;

  for (genvar k = 0; k < NTAP; k++) begin : g_lb
    conv_line_buffer #(
      .DATA_BITS(DATA_BITS),
      .DEPTH    (IMG_WIDTH),
      .ADDR_W   (CW)
    ) u_lb (
      .clk_i (clk),
      .en_i  (pix_val),
      .addr_i(col_cur),
      .din_i (tap[k]),
      .dout_o(tap[k+1])
    );
  end

  // Window rows shift left; the newest column enters at the right edge, oldest row on top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < FILTER_SIZE; r++) begin
        for (int c = 0; c < FILTER_SIZE; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (pix_val) begin
      for (int r = 0; r < FILTER_SIZE; r++) begin
        for (int c = 0; c < FILTER_SIZE - 1; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
        win_q[r][FILTER_SIZE-1] <= tap[FILTER_SIZE-1-r];
      end
    end
  end

  always_comb begin
    data_out = '0;
    for (int r = 0; r < FILTER_SIZE; r++) begin
      for (int c = 0; c < FILTER_SIZE; c++) begin
        data_out[(r*FILTER_SIZE+c)*DATA_BITS +: DATA_BITS] = win_q[r][c];
      end
    end
  end

  assign valid      = valid_q;
  assign frame_done = fdone_q;

endmodule
